// File: rtl/bus_arbiter.sv
// Two-master to one-slave bus arbiter. The dbus is favoured, but after
// D_STREAK_MAX back-to-back dbus grants a waiting ibus is served.
// Transfers that never complete are aborted with an error after TIMEOUT cycles.
//
// state | meaning
// IDLE  | no grant; all slave outputs low; arbitration happens here
// GNT_I | ibus owns the slave port
// GNT_D | dbus owns the slave port
module bus_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int D_STREAK_MAX = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_cyc,
  input  logic                i_we,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [DATA_W/8-1:0] i_sel,
  input  logic [DATA_W-1:0]   i_wdata,
  output logic                i_ack,
  output logic                i_err,
  input  logic                d_cyc,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_sel,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_ack,
  output logic                d_err,
  output logic [DATA_W-1:0]   rdata,
  output logic                m_cyc,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_sel,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ack,
  input  logic                m_err
);

  localparam int TO_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [2:0]      STREAK_MAX = 3'(D_STREAK_MAX);
  localparam logic [TO_W-1:0] TO_LIMIT   = TO_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  state_t          state, state_nxt;
  logic [2:0]      streak, streak_nxt;
  logic [TO_W-1:0] tmo_cnt;
  logic            tmo_hit;
  logic            g_cyc, rsp_ack, rsp_err, done;

  assign rdata   = m_rdata;
  assign tmo_hit = (state != IDLE) && (tmo_cnt == TO_LIMIT);

  // State and streak registers; reset forces IDLE so m_cyc drops at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      streak <= '0;
    end else begin
      state  <= state_nxt;
      streak <= streak_nxt;
    end
  end

  // Timeout counter: zero while idle, so it starts at 0 in the first grant cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt <= '0;
    end else if (state == IDLE) begin
      tmo_cnt <= '0;
    end else if (!tmo_hit && !m_ack && !m_err) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Arbitration, slave-port mux, response routing and streak bookkeeping.
  always_comb begin
    state_nxt  = state;
    streak_nxt = streak;
    m_cyc      = 1'b0;
    m_we       = 1'b0;
    m_addr     = '0;
    m_sel      = '0;
    m_wdata    = '0;
    i_ack      = 1'b0;
    i_err      = 1'b0;
    d_ack      = 1'b0;
    d_err      = 1'b0;
    g_cyc      = 1'b0;
    rsp_ack    = 1'b0;
    rsp_err    = 1'b0;
    done       = 1'b0;

    case (state)
      GNT_I: begin
        g_cyc   = i_cyc;
        m_we    = i_we;
        m_addr  = i_addr;
        m_sel   = i_sel;
        m_wdata = i_wdata;
      end
      GNT_D: begin
        g_cyc   = d_cyc;
        m_we    = d_we;
        m_addr  = d_addr;
        m_sel   = d_sel;
        m_wdata = d_wdata;
      end
      default: begin
        if (i_cyc && (!d_cyc || streak == STREAK_MAX)) begin
          state_nxt = GNT_I;
        end else if (d_cyc) begin
          state_nxt = GNT_D;
        end
      end
    endcase

    if (state != IDLE) begin
      // A timed-out transfer is cut from the slave in the cycle its error is reported.
      m_cyc = g_cyc & ~tmo_hit;
      if (!g_cyc) begin
        state_nxt = IDLE;
      end else if (tmo_hit) begin
        rsp_err   = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end else if (m_ack || m_err) begin
        rsp_ack   = m_ack;
        rsp_err   = ~m_ack;
        done      = 1'b1;
        state_nxt = IDLE;
      end

      if (state == GNT_I) begin
        i_ack = rsp_ack;
        i_err = rsp_err;
        if (done) streak_nxt = '0;
      end else begin
        d_ack = rsp_ack;
        d_err = rsp_err;
        if (done) begin
          if (!i_cyc) streak_nxt = '0;
          else if (streak != STREAK_MAX) streak_nxt = streak + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with default parameters.
module tb_bus_arbiter;

  logic        clk;
  logic        rst;
  logic        i_cyc, i_we, d_cyc, d_we;
  logic [31:0] i_addr, d_addr, i_wdata, d_wdata;
  logic [3:0]  i_sel, d_sel;
  logic        i_ack, i_err, d_ack, d_err;
  logic [31:0] rdata;
  logic        m_cyc, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [3:0]  m_sel;
  logic        m_ack, m_err;

  int n_assert = 0;
  int n_fail   = 0;

  bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_cyc(i_cyc), .i_we(i_we), .i_addr(i_addr), .i_sel(i_sel), .i_wdata(i_wdata),
    .i_ack(i_ack), .i_err(i_err),
    .d_cyc(d_cyc), .d_we(d_we), .d_addr(d_addr), .d_sel(d_sel), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err),
    .rdata(rdata),
    .m_cyc(m_cyc), .m_we(m_we), .m_addr(m_addr), .m_sel(m_sel), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack), .m_err(m_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    i_cyc = 0; i_we = 0; i_addr = 32'h100; i_sel = 4'hF; i_wdata = 32'h1111_0000;
    d_cyc = 0; d_we = 0; d_addr = 32'h200; d_sel = 4'h3; d_wdata = 32'hDEAD_BEEF;
    m_rdata = 32'hA5A5_A5A5; m_ack = 0; m_err = 0;

    // reset state
    #2;
    chk("rst_m_cyc", m_cyc, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_acks", {i_ack, i_err, d_ack, d_err}, 0);
    chk("rst_rdata", rdata, 32'hA5A5_A5A5);
    chk("rst_state", dut.state, 0);
    chk("rst_streak", dut.streak, 0);
    chk("rst_tmo", dut.tmo_cnt, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // simultaneous request: dbus first, bubble, then ibus
    i_cyc = 1; d_cyc = 1; d_we = 1; #1;
    chk("both_req_idle_m_cyc", m_cyc, 0);
    tick(); #1;
    chk("both_gnt_d_cyc", m_cyc, 1);
    chk("both_gnt_d_addr", m_addr, 32'h200);
    chk("both_gnt_d_we", m_we, 1);
    chk("both_gnt_d_wdata", m_wdata, 32'hDEAD_BEEF);
    chk("both_gnt_d_sel", m_sel, 4'h3);
    chk("both_gnt_d_noack", d_ack, 0);
    tick();
    m_ack = 1; #1;
    chk("both_d_ack", {d_ack, d_err, i_ack}, 3'b100);
    tick();
    m_ack = 0; d_cyc = 0; d_we = 0; #1;
    chk("both_bubble_m_cyc", m_cyc, 0);
    chk("both_streak_1", dut.streak, 1);
    tick(); #1;
    chk("both_gnt_i_addr", {m_cyc, m_addr}, {1'b1, 32'h100});
    chk("both_gnt_i_we", m_we, 0);
    m_ack = 1; m_rdata = 32'h1234_5678; #1;
    chk("both_i_ack", {i_ack, i_err, d_ack}, 3'b100);
    chk("both_rdata", rdata, 32'h1234_5678);
    tick();
    m_ack = 0; i_cyc = 0; #1;
    chk("both_streak_clr", dut.streak, 0);

    // responses in IDLE are ignored
    m_ack = 1; m_err = 1; #1;
    chk("idle_resp_ignored", {i_ack, i_err, d_ack, d_err, m_cyc}, 0);
    tick();
    m_ack = 0; m_err = 0; #1;
    chk("idle_resp_state", dut.state, 0);

    // starvation: four dbus transfers, then the ibus
    i_cyc = 1; d_cyc = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("starve_idle_m_cyc", m_cyc, 0);
      tick();
      m_ack = 1; #1;
      chk("starve_d_grant", m_addr, 32'h200);
      chk("starve_d_ack", {d_ack, i_ack}, 2'b10);
      tick();
      m_ack = 0;
    end
    #1;
    chk("starve_streak_sat", dut.streak, 4);
    tick();
    m_ack = 1; #1;
    chk("starve_i_grant", m_addr, 32'h100);
    chk("starve_i_ack", {i_ack, d_ack}, 2'b10);
    tick();
    m_ack = 0; i_cyc = 0; d_cyc = 0; #1;
    chk("starve_streak_0", dut.streak, 0);

    // timeout on an ibus read
    tick();
    i_cyc = 1; #1;
    tick(); #1;
    chk("tmo_grant", m_cyc, 1);
    for (int k = 1; k < 255; k++) begin
      tick(); #1;
      chk("tmo_wait", {m_cyc, i_err, i_ack}, 3'b100);
    end
    tick(); #1;
    chk("tmo_err", {m_cyc, i_err, i_ack, d_err}, 4'b0100);
    tick();
    i_cyc = 0; #1;
    chk("tmo_idle", {dut.state, i_err}, 3'b000);

    // dbus abort in its second grant cycle
    d_cyc = 1; #1;
    tick(); #1;
    chk("abort_c1", m_cyc, 1);
    tick();
    d_cyc = 0; m_ack = 1; #1;
    chk("abort_c2", {m_cyc, d_ack, d_err, i_ack}, 4'b0000);
    tick();
    m_ack = 0; #1;
    chk("abort_idle", dut.state, 0);

    // ack wins over err on ibus; err alone on dbus
    i_cyc = 1; #1;
    tick();
    m_ack = 1; m_err = 1; #1;
    chk("ack_wins", {i_ack, i_err}, 2'b10);
    tick();
    m_ack = 0; m_err = 0; i_cyc = 0;
    d_cyc = 1; #1;
    tick();
    m_err = 1; #1;
    chk("d_err_only", {d_ack, d_err, i_err}, 3'b010);
    tick();
    m_err = 0; d_cyc = 0;

    // reset in the middle of a dbus grant
    d_cyc = 1; #1;
    tick(); #1;
    chk("rst_mid_pre", m_cyc, 1);
    rst = 1'b0; m_ack = 1; #1;
    chk("rst_mid_m_cyc", {m_cyc, d_ack, d_err}, 3'b000);
    chk("rst_mid_state", dut.state, 0);
    d_cyc = 0; m_ack = 0;
    tick();
    rst = 1'b1;
    tick();
    i_cyc = 1; #1;
    chk("rst_post_n", m_cyc, 0);
    tick(); #1;
    chk("rst_post_n1", {m_cyc, m_addr}, {1'b1, 32'h100});
    i_cyc = 0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; sel width is DATA_W/8.
REQ-003 SHALL have parameter D_STREAK_MAX, default 4, consecutive dbus grants allowed while ibus waits.
REQ-004 SHALL have parameter TIMEOUT, default 255, slave cycles allowed before the arbiter aborts a transfer.
REQ-005 clk  in  1  sole clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 i_cyc  in  1  ibus request (cyc and stb combined), held until i_ack or i_err.
REQ-008 i_we  in  1  ibus write enable.
REQ-009 i_addr  in  ADDR_W  ibus address.
REQ-010 i_sel  in  DATA_W/8  ibus byte select.
REQ-011 i_wdata  in  DATA_W  ibus write data.
REQ-012 d_cyc, d_we, d_addr, d_sel, d_wdata: in, with widths as REQ-007..011, the dbus equivalents.
REQ-013 i_ack  out  1  ibus transfer done, one-cycle pulse.
REQ-014 i_err  out  1  ibus transfer failed (slave error or timeout), one-cycle pulse.
REQ-015 d_ack, d_err: out, 1 bit each, the dbus equivalents.
REQ-016 rdata  out  DATA_W  read data, shared by both masters; equals m_rdata.
REQ-017 m_cyc  out  1  slave request (cyc and stb combined).
REQ-018 m_we, m_addr, m_sel, m_wdata: out, the granted master's fields.
REQ-019 m_rdata  in  DATA_W  slave read data.
REQ-020 m_ack  in  1  slave acknowledge.
REQ-021 m_err  in  1  slave error.

Function
REQ-022 SHALL implement the FSM states IDLE, GNT_I and GNT_D.
REQ-023 In IDLE, all m_* outputs SHALL be 0.
REQ-024 In IDLE with d_cyc=1, the FSM SHALL go to GNT_D next cycle, unless the ibus has starved (REQ-026).
REQ-025 In IDLE with only i_cyc=1, the FSM SHALL go to GNT_I next cycle.
REQ-026 Starvation rule: if streak==D_STREAK_MAX and i_cyc=1 in IDLE, the FSM SHALL go to GNT_I, even when d_cyc=1.
REQ-027 The 3-bit streak counter SHALL increment when a GNT_D transfer ends while i_cyc=1.
REQ-028 The streak counter SHALL clear when a GNT_I transfer ends, or when a GNT_D transfer ends with i_cyc=0.
REQ-029 The streak counter SHALL saturate at D_STREAK_MAX.
REQ-030 In GNT_x, m_cyc/we/addr/sel/wdata SHALL combinationally equal x_cyc/we/addr/sel/wdata.
REQ-031 In GNT_x, x_ack SHALL equal m_ack and x_err SHALL equal m_err; the non-granted master's ack and err SHALL be 0.
REQ-032 In GNT_x with m_ack or m_err set, the FSM SHALL return to IDLE next cycle, leaving one bubble between transfers.
REQ-033 Latency: a request made in IDLE at cycle N SHALL appear on m_cyc in cycle N+1.
REQ-034 Abort: if x_cyc drops while in GNT_x, m_cyc SHALL drop in the same cycle, the FSM SHALL go to IDLE, and no ack or err SHALL be issued.
REQ-035 The timeout counter SHALL clear on entering GNT_x and increment each cycle in GNT_x without m_ack or m_err.
REQ-036 When the timeout counter reaches TIMEOUT, the arbiter SHALL pulse x_err for one cycle, force m_cyc=0 in that cycle, and return to IDLE.
REQ-037 If m_ack and m_err are both set, ack SHALL win: x_ack=1 and x_err=0.
REQ-038 An m_ack or m_err arriving in IDLE SHALL be ignored.

Reset
REQ-039 While rst=0: state IDLE, streak=0, timeout counter=0, and all outputs 0 except rdata, which follows m_rdata.
REQ-040 Reset asserted mid-transfer SHALL drop m_cyc asynchronously; no ack or err SHALL be produced.

Verification
REQ-041 i_cyc=1 and d_cyc=1 in the same cycle, slave acks after 2 cycles -> GNT_D first, d_ack pulses, one IDLE cycle, then GNT_I and i_ack.
REQ-042 d_cyc held high continuously, i_cyc high, D_STREAK_MAX=4 -> exactly 4 dbus transfers complete, then one ibus transfer, then the streak counter is 0.
REQ-043 Granted ibus read, m_ack never arrives, TIMEOUT=255 -> i_err pulses 255 cycles after grant, m_cyc=0 in that cycle, FSM in IDLE.
REQ-044 d_cyc drops in the 2nd GNT_D cycle -> m_cyc=0 the same cycle, d_ack=d_err=0, then IDLE.
REQ-045 m_ack=m_err=1 during GNT_I -> i_ack=1, i_err=0.
REQ-046 rst pulled low during GNT_D -> m_cyc=0 immediately; after release, state IDLE and a new i_cyc is granted at N+1.
